// File: rtl/glyph_addr_gen.sv
// glyph_addr_gen: pipelined font-ROM line address generator with single-line and whole-glyph burst modes.
// Define GLYPH_ADDR_INVERT_EN to map MSB-set codes to inverse-video glyphs.
module glyph_addr_gen #(
    parameter int ASCII_WIDTH  = 8,
    parameter int ADDR_WIDTH   = 11,
    parameter int CHARA_HEIGHT = 11,
    parameter int FIRST_CODE   = 32,
    parameter int LAST_CODE    = 127,
    parameter int BAD_GLYPH    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ASCII_WIDTH-1:0] in_ascii,
    input  logic [3:0]             in_line,
    input  logic                   in_burst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic [3:0]             out_line,
    output logic                   out_last,
    output logic                   out_bad,
    output logic                   out_invert
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_next;
    logic [ASCII_WIDTH-1:0] code;
    logic                   inv;
    logic [31:0]            code32, idx, base_full, addr_full;
    logic                   in_range, clamp, accept, adv;
    logic [3:0]             line_sel, nxt_line;
    logic [ADDR_WIDTH-1:0]  base;
`ifdef GLYPH_ADDR_INVERT_EN
    assign code = {1'b0, in_ascii[ASCII_WIDTH-2:0]};
    assign inv  = in_ascii[ASCII_WIDTH-1];
`else
    assign code = in_ascii;
    assign inv  = 1'b0;
`endif
    always_comb begin
        code32    = 32'(code);
        in_range  = (code32 >= 32'(FIRST_CODE)) && (code32 <= 32'(LAST_CODE));
        idx       = in_range ? code32 - 32'(FIRST_CODE) : 32'(BAD_GLYPH);
        clamp     = !in_burst && (32'(in_line) >= 32'(CHARA_HEIGHT));
        line_sel  = in_burst ? 4'd0 : clamp ? 4'(CHARA_HEIGHT - 1) : in_line;
        base_full = idx * 32'(CHARA_HEIGHT);
        addr_full = base_full + 32'(line_sel);
        nxt_line  = out_line + 4'd1;
        adv       = out_valid && out_ready;
        // The final burst beat frees the input so a new request can follow with no bubble.
        in_ready  = (state == IDLE || out_last) && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
        state_next = accept ? ((in_burst && CHARA_HEIGHT > 1) ? BURST : IDLE)
                   : (state == BURST && adv && out_last) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_line   <= '0;
            out_last   <= 1'b0;
            out_bad    <= 1'b0;
            out_invert <= 1'b0;
            base       <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_addr   <= addr_full[ADDR_WIDTH-1:0];
            out_line   <= line_sel;
            out_last   <= !in_burst || CHARA_HEIGHT == 1;
            out_bad    <= !in_range || clamp;
            out_invert <= inv;
            base       <= base_full[ADDR_WIDTH-1:0];
        end else if (state == BURST && adv && !out_last) begin
            out_line <= nxt_line;
            out_addr <= base + ADDR_WIDTH'(nxt_line);
            out_last <= nxt_line == 4'(CHARA_HEIGHT - 1);
        end else if (adv) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/glyph_addr_gen.md
# glyph_addr_gen

Pipelined font-ROM address generator for the text display path. It accepts character requests (code plus glyph line) over a valid/ready handshake and emits registered font-ROM line addresses to the ROM read stage. It generalises the fixed 32..127 × 11 combinational decode: the code range, glyph height and fallback glyph are parameters, out-of-range lines are flagged, and a burst mode emits every line of one glyph back-to-back.

## Interface
- ASCII_WIDTH, 8, character code width
- ADDR_WIDTH, 11, font-ROM address width
- CHARA_HEIGHT, 11, lines per glyph (2..16)
- FIRST_CODE, 32, lowest renderable code
- LAST_CODE, 127, highest renderable code
- BAD_GLYPH, 0, glyph index substituted for out-of-range codes
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready
- in_ascii  in  ASCII_WIDTH  character code
- in_line  in  4  glyph line (ignored in burst)
- in_burst  in  1  1 = emit all CHARA_HEIGHT lines, 0 = single line
- out_valid  out  1  address beat present
- out_ready  in  1  downstream accepts beat
- out_addr  out  ADDR_WIDTH  font-ROM line address
- out_line  out  4  line number of this beat
- out_last  out  1  final beat of the request (always 1 for single)
- out_bad  out  1  code out of range or line clamped
- out_invert  out  1  inverse-video flag (see Configuration)

## Operation
- Glyph index: code − FIRST_CODE if FIRST_CODE ≤ code ≤ LAST_CODE, else BAD_GLYPH with out_bad=1.
- Address: index × CHARA_HEIGHT + line, computed at full width, truncated to ADDR_WIDTH.
- Single mode: line = in_line; if in_line ≥ CHARA_HEIGHT, line = CHARA_HEIGHT−1 and out_bad=1.
- FSM states: IDLE, BURST.
  - IDLE: in_ready = !out_valid || out_ready. A single request loads the output register and the FSM stays in IDLE. A burst request loads line 0 and moves to BURST, or stays in IDLE when CHARA_HEIGHT=1.
  - BURST: in_ready=0. On each out_valid && out_ready the line counter increments and the next address loads. The beat with line CHARA_HEIGHT−1 carries out_last=1. When that beat is accepted, the FSM returns to IDLE.
- Code, out_bad and out_invert are captured once per request and are constant across all burst beats.
- Output register holds all out_* fields stable while out_valid && !out_ready. No beat is dropped or duplicated.

## Timing
- Latency: request accepted at edge N → out_valid high after edge N.
- Throughput: one single request per cycle with out_ready held high. A burst takes CHARA_HEIGHT beats on consecutive cycles.
- Back-to-back: a new request may be accepted in the same cycle the last beat of a burst is accepted.
- Reset (asynchronous, any time including mid-burst): state=IDLE, out_valid=0, out_addr=0, out_line=0, out_last=0, out_bad=0, out_invert=0, line counter=0. An in-flight burst is discarded. in_ready is 1 in the first cycle after reset release.

## Configuration
- GLYPH_ADDR_INVERT_EN defined:
  - Codes with the MSB set render the glyph of code − 2^(ASCII_WIDTH−1), with out_invert=1.
  - Range check applies to the stripped code.
- GLYPH_ADDR_INVERT_EN undefined:
  - out_invert is constant 0.
  - Codes with the MSB set are range-checked as-is; with the defaults they are out of range.

## Test plan
- Single request 65 ('A'), line 3, out_ready=1 → next cycle out_addr=366, out_line=3, out_last=1, out_bad=0.
- Single request code 10, line 5 → out_addr=5, out_bad=1. Single request 65, line 13 → out_addr=373 (line clamped to 10), out_bad=1.
- Burst request 33 → 11 consecutive beats with out_addr 11..21, out_last only on 21. in_ready=0 from the cycle after accept until the last beat is accepted.
- Burst request 33 with out_ready low for 3 cycles at beat out_addr=15 → out_addr held at 15. Full sequence 11..21 delivered with no gaps or repeats. rst pulsed mid-burst → out_valid=0 immediately, in_ready=1 after release.
- Single request 127 line 10 → out_addr=1055, which is truncated correctly within 11 bits.
- Macro on: code 0xC1, line 3 → out_addr=366, out_invert=1, out_bad=0. Macro off: same stimulus → out_addr=3, out_bad=1, out_invert=0.
